// File: rtl/biquad_ch_scheduler.sv
// Time-multiplexes NCH sample streams onto one biquad core, one sample in flight at a time.
// Capture-to-result latency is 2 cycles plus core latency; a stalled m_axis holds the FSM in OUT and blocks further issue.
module biquad_ch_scheduler #(
    parameter int NCH     = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           s_axis_tvalid,
    input  logic [NCH*DW-1:0]        s_axis_tdata,
    output logic [NCH-1:0]           s_axis_tready,
    output logic                     core_tvalid,
    output logic [DW-1:0]            core_tdata,
    output logic [$clog2(NCH)-1:0]   core_ch,
    input  logic                     core_result_tvalid,
    input  logic [DW-1:0]            core_result_tdata,
    output logic                     m_axis_tvalid,
    output logic [DW-1:0]            m_axis_tdata,
    output logic [$clog2(NCH)-1:0]   m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic                     busy,
    output logic                     timeout_err,
    output logic                     spurious_err
);

    localparam int CW = $clog2(NCH);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [CW-1:0]   last_q, last_d;
    logic [TW-1:0]   wcnt_q, wcnt_d;

    logic [NCH-1:0]  full_q, full_d;
    logic [DW-1:0]   hold_q [NCH];
    logic [DW-1:0]   hold_d [NCH];
    logic [DW-1:0]   res_q, res_d;
    logic [CW-1:0]   tag_q, tag_d;
    logic            tmo_q, tmo_d;
    logic            spur_q, spur_d;

    logic            core_vld_q, core_vld_d;
    logic [DW-1:0]   core_dat_q, core_dat_d;
    logic            m_vld_q, m_vld_d;
    logic            busy_q, busy_d;

    logic            gnt_vld;
    logic [CW-1:0]   gnt_idx;
    logic [CW:0]     rr_sum;
    logic            wait_expired;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        for (int k = 0; k < NCH; k++) begin
            rr_sum = {1'b0, last_q} + (CW+1)'(k + 1);
            if (rr_sum >= (CW+1)'(NCH)) begin
                rr_sum = rr_sum - (CW+1)'(NCH);
            end
            if (!gnt_vld && full_q[rr_sum[CW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_sum[CW-1:0];
            end
        end
    end

    assign wait_expired = (state_q == WAIT) && !core_result_tvalid &&
                          (wcnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            last_q  <= CW'(NCH - 1);
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    state_d = ISSUE;
                    ch_d    = gnt_idx;
                    last_d  = gnt_idx;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                if (core_result_tvalid) begin
                    state_d = OUT;
                end else if (wait_expired) begin
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            OUT: begin
                if (m_axis_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they align with it.
    always_comb begin
        core_vld_d = (state_d == ISSUE);
        m_vld_d    = (state_d == OUT);
        busy_d     = (state_d != IDLE);
        core_dat_d = core_dat_q;
        if (state_q == IDLE && gnt_vld) begin
            core_dat_d = hold_q[gnt_idx];
        end
    end

    always_comb begin
        full_d = full_q;
        for (int i = 0; i < NCH; i++) begin
            hold_d[i] = hold_q[i];
            if (s_axis_tvalid[i] && !full_q[i]) begin
                full_d[i] = 1'b1;
                hold_d[i] = s_axis_tdata[i*DW +: DW];
            end
        end
        // A full channel has ready low, so this clear never races a capture.
        if (state_q == ISSUE) begin
            full_d[ch_q] = 1'b0;
        end

        res_d = res_q;
        tag_d = tag_q;
        if (state_q == WAIT && core_result_tvalid) begin
            res_d = core_result_tdata;
            tag_d = ch_q;
        end

        tmo_d  = tmo_q | wait_expired;
        spur_d = spur_q | (core_result_tvalid && state_q != WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= '0;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= '0;
            end
            res_q      <= '0;
            tag_q      <= '0;
            tmo_q      <= 1'b0;
            spur_q     <= 1'b0;
            core_vld_q <= 1'b0;
            core_dat_q <= '0;
            m_vld_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            full_q     <= full_d;
            for (int i = 0; i < NCH; i++) begin
                hold_q[i] <= hold_d[i];
            end
            res_q      <= res_d;
            tag_q      <= tag_d;
            tmo_q      <= tmo_d;
            spur_q     <= spur_d;
            core_vld_q <= core_vld_d;
            core_dat_q <= core_dat_d;
            m_vld_q    <= m_vld_d;
            busy_q     <= busy_d;
        end
    end

    assign s_axis_tready = ~full_q;
    assign core_tvalid   = core_vld_q;
    assign core_tdata    = core_dat_q;
    assign core_ch       = ch_q;
    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = res_q;
    assign m_axis_tuser  = tag_q;
    assign busy          = busy_q;
    assign timeout_err   = tmo_q;
    assign spurious_err  = spur_q;

endmodule

// File: tb/tb_biquad_ch_scheduler.sv
// Directed bench for biquad_ch_scheduler with a behavioural core that returns 2x the sample after a set latency.
module tb_biquad_ch_scheduler;

    localparam int NCH     = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    s_vld;
    logic [NCH*DW-1:0] s_dat;
    logic [NCH-1:0]    s_rdy;
    logic              core_vld;
    logic [DW-1:0]     core_dat;
    logic [1:0]        core_ch;
    logic              core_result_tvalid;
    logic [DW-1:0]     core_result_tdata;
    logic              m_vld;
    logic [DW-1:0]     m_dat;
    logic [1:0]        m_user;
    logic              m_rdy;
    logic              busy;
    logic              tmo;
    logic              spur;

    biquad_ch_scheduler #(.NCH(NCH), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tvalid      (s_vld),
        .s_axis_tdata       (s_dat),
        .s_axis_tready      (s_rdy),
        .core_tvalid        (core_vld),
        .core_tdata         (core_dat),
        .core_ch            (core_ch),
        .core_result_tvalid (core_result_tvalid),
        .core_result_tdata  (core_result_tdata),
        .m_axis_tvalid      (m_vld),
        .m_axis_tdata       (m_dat),
        .m_axis_tuser       (m_user),
        .m_axis_tready      (m_rdy),
        .busy               (busy),
        .timeout_err        (tmo),
        .spurious_err       (spur)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural core: result = sample << 1, presented core_lat cycles after acceptance.
    logic          mdl_vld = 1'b0;
    logic          inj_vld = 1'b0;
    logic [DW-1:0] mdl_dat = '0;
    int            mdl_cnt = -1;
    int            core_lat = 5;
    bit            core_en = 1'b1;

    assign core_result_tvalid = mdl_vld | inj_vld;
    assign core_result_tdata  = mdl_dat;

    always @(negedge clk) begin
        if (rst) begin
            mdl_cnt = -1;
            mdl_vld = 1'b0;
        end else begin
            mdl_vld = 1'b0;
            if (mdl_cnt > 0) begin
                mdl_cnt--;
                if (mdl_cnt == 0) begin
                    mdl_vld = 1'b1;
                    mdl_cnt = -1;
                end
            end
            if (core_vld && core_en) begin
                mdl_cnt = core_lat;
                mdl_dat = {core_dat[DW-2:0], 1'b0};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    typedef struct {
        int          ch;
        logic [15:0] din;
        int          lat;
        logic [15:0] exp_dat;
        int          exp_user;
        int          exp_cyc;
    } vec_t;

    vec_t vecs[5];

    // Presents one sample on channel ch, returns edges from capture to m_axis_tvalid.
    task automatic txn(input int ch, input logic [15:0] din, input int lat, output int cyc);
        core_lat = lat;
        s_dat[ch*DW +: DW] = din;
        s_vld[ch] = 1'b1;
        @(posedge clk); #1;
        s_vld[ch] = 1'b0;
        cyc = 0;
        while (!m_vld && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((busy || s_rdy != 4'hF) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {30'd0, busy, (s_rdy == 4'hF)}, 32'd1);
    endtask

    task automatic wait_out(input int limit);
        int n = 0;
        while (!m_vld && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int cyc;
        int got[$];
        int bad_stable;
        int bad_issue;

        vecs[0] = '{0, 16'd100,   5, 16'd200,   0, 7};
        vecs[1] = '{2, 16'hFFCE,  1, 16'hFF9C,  2, 3};
        vecs[2] = '{3, 16'h1234,  3, 16'h2468,  3, 5};
        vecs[3] = '{1, 16'h7FFF,  2, 16'hFFFE,  1, 4};
        vecs[4] = '{0, 16'h0000,  8, 16'h0000,  0, 10};

        rst   = 1'b1;
        s_vld = '0;
        s_dat = '0;
        m_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_core_tvalid", core_vld, 0);
        check("rst_m_tvalid",    m_vld,    0);
        check("rst_busy",        busy,     0);
        check("rst_timeout_err", tmo,      0);
        check("rst_spurious",    spur,     0);
        check("rst_tready",      s_rdy,    4'hF);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single-channel transactions with varied latency and data.
        for (int i = 0; i < 5; i++) begin
            txn(vecs[i].ch, vecs[i].din, vecs[i].lat, cyc);
            check($sformatf("vec%0d_latency", i), cyc, vecs[i].exp_cyc);
            check($sformatf("vec%0d_tdata", i), m_dat, vecs[i].exp_dat);
            check($sformatf("vec%0d_tuser", i), m_user, vecs[i].exp_user);
            @(posedge clk); #1;
            check($sformatf("vec%0d_release", i), {busy, m_vld}, 0);
        end

        // Re-reset so all four channels start with last_grant = NCH-1.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        core_lat = 2;
        s_dat = {16'd4, 16'd3, 16'd2, 16'd1};
        s_vld = 4'hF;
        cyc = 0;
        while (got.size() < 8 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            if (core_vld) got.push_back(int'(core_ch));
        end
        s_vld = '0;
        check("rr_issue_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("rr_order%0d", i), got[i], i % 4);
        end
        drain("rr_drain");

        // Backpressure: result must hold and nothing else may issue.
        m_rdy = 1'b0;
        txn(1, 16'd7, 3, cyc);
        check("bp_first_valid", m_vld, 1);
        s_dat[2*DW +: DW] = 16'd9;
        s_vld[2] = 1'b1;
        bad_stable = 0;
        bad_issue  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            s_vld[2] = 1'b0;
            if (!m_vld || m_dat !== 16'd14 || m_user !== 2'd1) bad_stable++;
            if (core_vld) bad_issue++;
        end
        check("bp_stable_cycles", bad_stable, 0);
        check("bp_no_issue", bad_issue, 0);
        m_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_accept", m_vld, 0);
        @(posedge clk); #1;
        check("bp_next_issue", {core_vld, core_ch}, {1'b1, 2'd2});
        wait_out(20);
        check("bp_next_result", {m_vld, m_user, m_dat}, {1'b1, 2'd2, 16'd18});
        drain("bp_drain");

        // Core never answers: timeout on the 64th WAIT cycle.
        core_en = 1'b0;
        s_dat[3*DW +: DW] = 16'd5;
        s_vld[3] = 1'b1;
        @(posedge clk); #1;
        s_vld[3] = 1'b0;
        @(posedge clk); #1;
        check("to_issue", {core_vld, core_ch}, {1'b1, 2'd3});
        s_dat[0 +: DW] = 16'd21;
        s_vld[0] = 1'b1;
        @(posedge clk); #1;
        s_vld[0] = 1'b0;
        repeat (63) @(posedge clk);
        #1;
        check("to_before_limit", {tmo, busy}, {1'b0, 1'b1});
        @(posedge clk); #1;
        check("to_at_limit", {tmo, busy, m_vld}, {1'b1, 1'b0, 1'b0});
        core_en = 1'b1;
        @(posedge clk); #1;
        check("to_next_issue", {core_vld, core_ch}, {1'b1, 2'd0});
        wait_out(20);
        check("to_next_result", {m_vld, m_user, m_dat}, {1'b1, 2'd0, 16'd42});
        drain("to_drain");

        // Result strobe while idle.
        check("sp_before", spur, 0);
        inj_vld = 1'b1;
        @(posedge clk); #1;
        inj_vld = 1'b0;
        check("sp_flag", spur, 1);
        check("sp_no_output", {m_vld, busy}, 0);
        @(posedge clk); #1;
        check("sp_no_output_late", m_vld, 0);

        // Reset while waiting on the core.
        core_en = 1'b0;
        s_dat[1*DW +: DW] = 16'd3;
        s_vld[1] = 1'b1;
        @(posedge clk); #1;
        s_vld[1] = 1'b0;
        s_dat[2*DW +: DW] = 16'd8;
        s_vld[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_vld[2] = 1'b0;
        check("rw_in_wait", {busy, s_rdy[2]}, {1'b1, 1'b0});
        rst = 1'b1;
        #1;
        check("rw_outputs", {core_vld, m_vld, busy, tmo, spur, m_user, core_ch}, 0);
        check("rw_data", {m_dat, core_dat}, 0);
        check("rw_tready", s_rdy, 4'hF);
        @(posedge clk); #1;
        rst = 1'b0;
        core_en = 1'b1;
        inj_vld = 1'b1;
        @(posedge clk); #1;
        inj_vld = 1'b0;
        bad_stable = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_vld || busy || core_vld) bad_stable++;
            @(posedge clk); #1;
        end
        check("rw_late_dropped", bad_stable, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
